id_ex_stage: RTL and testbench

- Pipeline register between decode (ID) and execute (EX) of the 5-stage RV32I core.
- Captures decoder control bits, register-file read data, immediate, PC and register indices from ID, and presents them to EX one cycle later.
- Contains the load-use hazard detector. It raises a stall to hold PC and IF/ID, and injects a bubble into EX.
- Honours a branch/jump flush from EX and a global hold from the memory stage. Keeps a saturating stall counter for performance reporting.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/id_ex_stage_hazard_unit.sv | 42 ++++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ID/EX control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Decoder control bundle carried from ID into EX; all-zero is a bubble.
  typedef struct packed {
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
    logic       ALUSrc;
    logic       regWrite;
    logic [1:0] ALUOp;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection: operand-usage decode plus the stall request.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  input  logic              hold,
  output logic              load_use_c,
  output logic              stall_c
);

  logic uses_rs1_c;
  logic uses_rs2_c;

  always_comb begin
    uses_rs1_c = 1'b0;
    uses_rs2_c = 1'b0;
    case (id_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
      end
      OP_LOAD, OP_IMM, OP_JALR: uses_rs1_c = 1'b1;
      default: ;
    endcase

    // x0 is never a real producer, so a load into it cannot create a hazard.
    load_use_c = id_valid & ex_valid & ex_memRead & (ex_rd != '0) &
                 ((uses_rs1_c & (ex_rd == id_rs1)) | (uses_rs2_c & (ex_rd == id_rs2)));
    stall_c    = load_use_c & ~flush & ~hold & ~rst;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold and a stall counter.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_branch,
  input  logic              id_memRead,
  input  logic              id_memToReg,
  input  logic              id_memWrite,
  input  logic              id_ALUSrc,
  input  logic              id_regWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7b5,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1Data,
  input  logic [XLEN-1:0]   id_rs2Data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_memRead,
  output logic              ex_memToReg,
  output logic              ex_memWrite,
  output logic              ex_ALUSrc,
  output logic              ex_regWrite,
  output logic [1:0]        ex_ALUOp,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1Data,
  output logic [XLEN-1:0]   ex_rs2Data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_t id_ctrl_c;
  ctrl_t ex_ctrl_q;
  logic  load_use_c;
  logic  stall_c;

  assign id_ctrl_c = {id_branch, id_memRead, id_memToReg, id_memWrite,
                      id_ALUSrc, id_regWrite, id_ALUOp};

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .rst        (rst),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (ex_valid),
    .ex_memRead (ex_ctrl_q.memRead),
    .ex_rd      (ex_rd),
    .flush      (flush),
    .hold       (hold),
    .load_use_c (load_use_c),
    .stall_c    (stall_c)
  );

  assign stall = stall_c;

  // Flush beats hold, hold beats the load-use bubble, else capture ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || (!hold && load_use_c)) begin
      ex_valid    <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1Data  <= '0;
      ex_rs2Data  <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_ctrl_q   <= id_valid ? id_ctrl_c : '0;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1Data  <= id_rs1Data;
      ex_rs2Data  <= id_rs2Data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end

  // Counts only cycles where the bubble was actually injected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_c && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_memRead  = ex_ctrl_q.memRead;
  assign ex_memToReg = ex_ctrl_q.memToReg;
  assign ex_memWrite = ex_ctrl_q.memWrite;
  assign ex_ALUSrc   = ex_ctrl_q.ALUSrc;
  assign ex_regWrite = ex_ctrl_q.regWrite;
  assign ex_ALUOp    = ex_ctrl_q.ALUOp;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a rule-level reference model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        id_valid, id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite;
  logic [6:0]  id_opcode;
  logic [1:0]  id_ALUOp;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1Data, id_rs2Data, id_imm, id_pc;
  logic        flush, hold;

  logic        ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [1:0]  ex_ALUOp;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1Data, ex_rs2Data, ex_imm, ex_pc;
  logic        stall;
  logic [15:0] stall_count;

  logic        b_valid, b_branch, b_memRead, b_memToReg, b_memWrite, b_ALUSrc, b_regWrite;
  logic [1:0]  b_ALUOp;
  logic [2:0]  b_funct3;
  logic        b_funct7b5;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [31:0] b_rs1Data, b_rs2Data, b_imm, b_pc;
  logic        b_stall;
  logic [2:0]  b_stall_count;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc), .id_regWrite(id_regWrite),
    .id_ALUOp(id_ALUOp), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1Data(id_rs1Data),
    .id_rs2Data(id_rs2Data), .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memRead(ex_memRead),
    .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_regWrite(ex_regWrite), .ex_ALUOp(ex_ALUOp), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .stall(stall), .stall_count(stall_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc), .id_regWrite(id_regWrite),
    .id_ALUOp(id_ALUOp), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1Data(id_rs1Data),
    .id_rs2Data(id_rs2Data), .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .hold(hold),
    .ex_valid(b_valid), .ex_branch(b_branch), .ex_memRead(b_memRead),
    .ex_memToReg(b_memToReg), .ex_memWrite(b_memWrite), .ex_ALUSrc(b_ALUSrc),
    .ex_regWrite(b_regWrite), .ex_ALUOp(b_ALUOp), .ex_funct3(b_funct3),
    .ex_funct7b5(b_funct7b5), .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd),
    .ex_rs1Data(b_rs1Data), .ex_rs2Data(b_rs2Data), .ex_imm(b_imm), .ex_pc(b_pc),
    .stall(b_stall), .stall_count(b_stall_count)
  );

  localparam logic [7:0] C_R   = 8'b000001_10;
  localparam logic [7:0] C_LW  = 8'b011011_00;
  localparam logic [7:0] C_SW  = 8'b000110_00;
  localparam logic [7:0] C_LUI = 8'b000011_00;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

  int errors = 0;
  int checks = 0;

  // Expected EX-side contents; ctrl is {branch,memRead,memToReg,memWrite,ALUSrc,regWrite,ALUOp}.
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  int          m_cnt, m_cnt_sat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit model_load_use();
    return id_valid && m_valid && m_ctrl[6] && (m_rd != 5'd0) &&
           ((reads_rs1(id_opcode) && m_rd == id_rs1) || (reads_rs2(id_opcode) && m_rd == id_rs2));
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_ctrl = '0; m_f3 = '0; m_f7 = 1'b0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, ".ctrl"}, 64'({ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc,
                             ex_regWrite, ex_ALUOp}), 64'(m_ctrl));
    chk({tag, ".funct"}, 64'({ex_funct3, ex_funct7b5}), 64'({m_f3, m_f7}));
    chk({tag, ".regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
    chk({tag, ".data"}, {ex_rs1Data, ex_rs2Data}, {m_d1, m_d2});
    chk({tag, ".immpc"}, {ex_imm, ex_pc}, {m_imm, m_pc});
    chk({tag, ".cnt"}, 64'(stall_count), 64'(m_cnt));
    chk({tag, ".cnt_sat"}, 64'(b_stall_count), 64'(m_cnt_sat));
  endtask

  // Called #1 after a rising edge; checks stall, clocks once, updates model, checks EX.
  task automatic step(input int exp_stall = -1);
    bit lu, st;
    lu = model_load_use();
    st = lu && !flush && !hold;
    #1;
    chk("stall", 64'(stall), 64'(st));
    if (exp_stall >= 0) chk("stall_dir", 64'(stall), 64'(exp_stall));
    @(posedge clk);
    if (flush || (!hold && lu)) begin
      model_bubble();
      if (!flush && lu) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 7) m_cnt_sat++;
      end
    end else if (!hold) begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? {id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc,
                            id_regWrite, id_ALUOp} : 8'h00;
      m_f3 = id_funct3; m_f7 = id_funct7b5;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_rs1Data; m_d2 = id_rs2Data; m_imm = id_imm; m_pc = id_pc;
    end
    #1;
    check_all("ex");
  endtask

  task automatic instr(input logic v, input logic [6:0] op, input logic [7:0] c,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_opcode = op;
    {id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite, id_ALUOp} = c;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
    id_rs1Data = $urandom; id_rs2Data = $urandom; id_imm = $urandom; id_pc = $urandom;
  endtask

  // Asserts reset between edges and checks the clear happens without a clock.
  task automatic mid_reset();
    #3 rst = 1'b1;
    #1;
    model_bubble();
    m_cnt = 0; m_cnt_sat = 0;
    chk("rst_stall", 64'(stall), 64'(0));
    check_all("rst");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    instr(1'b0, 7'd0, 8'h00, 5'd0, 5'd0, 5'd0);
    model_bubble(); m_cnt = 0; m_cnt_sat = 0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    instr(1'b1, 7'b0110011, C_R, 5'd1, 5'd2, 5'd3);
    id_rs1Data = 32'd5; id_rs2Data = 32'd7; id_pc = 32'h100;
    step(0);
    chk("pt_rd", 64'(ex_rd), 64'(3));
    chk("pt_ops", {ex_rs1Data, ex_rs2Data}, {32'd5, 32'd7});
    chk("pt_pc", 64'(ex_pc), 64'h100);
    chk("pt_ctl", 64'({ex_regWrite, ex_ALUOp}), 64'(3'b110));
    mid_reset();

    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0110011, C_R, 5'd5, 5'd2, 5'd6); step(1);
    chk("lu_bubble", 64'({ex_valid, ex_regWrite}), 64'(0));
    chk("lu_cnt", 64'(stall_count), 64'(1));
    step(0);
    chk("lu_add", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd6}));

    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd0); step(0);
    instr(1'b1, 7'b0110011, C_R, 5'd0, 5'd0, 5'd6); step(0);
    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0110111, C_LUI, 5'd5, 5'd5, 5'd5); step(0);
    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0100011, C_SW, 5'd5, 5'd7, 5'd0); step(1); step(0);

    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0110011, C_R, 5'd5, 5'd2, 5'd6); flush = 1'b1; step(0);
    flush = 1'b0;
    chk("fl_cnt", 64'(stall_count), 64'(2));

    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0110011, C_R, 5'd2, 5'd5, 5'd6); hold = 1'b1;
    repeat (3) step(0);
    chk("hold_frz", 64'({ex_valid, ex_memRead, ex_rd}), 64'({2'b11, 5'd5}));
    hold = 1'b0; step(1); step(0);

    repeat (8) begin
      instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd4); step(0);
      instr(1'b1, 7'b1100011, 8'b100000_01, 5'd3, 5'd4, 5'd0); step(1); step(0);
    end
    chk("sat", 64'(b_stall_count), 64'(7));

    instr(1'b1, 7'b0000011, C_LW, 5'd1, 5'd0, 5'd5); step(0);
    instr(1'b1, 7'b0110011, C_R, 5'd5, 5'd2, 5'd6);
    #1 chk("pre_rst_stall", 64'(stall), 64'(1));
    mid_reset();
    step(0);

    for (int i = 0; i < 2000; i++) begin
      instr($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)], 8'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
